cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Control stage directly upstream of the 16-bit CPU datapath.
- Holds the instruction register and decodes the instruction fields.
- Runs a Moore FSM that sequences the datapath enables (register file, A/B/C, status, muxes) to execute one instruction per start pulse.
- Outputs connect one-to-one to the datapath control and immediate inputs.

Parameters:
- None. Widths are fixed by the ISA: 16-bit instruction, 8 registers.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; sampled on rising clk
in  in  16  instruction word to load
load  in  1  IR load strobe (honoured only in WAIT)
s  in  1  start strobe (honoured only in WAIT)
w  out  1  1 = idle in WAIT, ready for load/s
r_addr  out  3  regfile read address
w_addr  out  3  regfile write address
w_en  out  1  regfile write enable
wb_sel  out  2  writeback select: 00 C, 01 pc, 10 sximm8, 11 mdata
en_A  out  1  load A register
en_B  out  1  load B register
en_C  out  1  load C register
en_status  out  1  load Z/N/V status
sel_A  out  1  1 = ALU A input forced to zero
sel_B  out  1  1 = ALU B input is sximm5
ALU_op  out  2  00 add, 01 sub, 10 and, 11 not-B
shift_op  out  2  IR[4:3], combinational from IR
sximm8  out  16  sign-extended IR[7:0]
sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
- IR: 16-bit register, cleared on reset. IR <= in on the edge where load=1 and state=WAIT. load in any other state is ignored.
- FSM states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, COMPUTE, WRITE_REG. Reset state is WAIT.
- All outputs are Moore (decoded from state plus IR). Enables, w_en, sel_A, sel_B, en_status default to 0; wb_sel defaults to 00; r_addr/w_addr default to 000.
- WAIT: w=1. s=1 -> DECODE; otherwise stay.
- DECODE: MOV imm -> WRITE_IMM; ADD/CMP/AND -> GET_A; MOV reg or MVN -> GET_B; any other opcode/op -> WAIT (no side effects).
- WRITE_IMM: w_addr=Rn, wb_sel=10, w_en=1 -> WAIT.
- GET_A: r_addr=Rn, en_A=1 -> GET_B.
- GET_B: r_addr=Rm, en_B=1 -> COMPUTE.
- COMPUTE: sel_B=0; sel_A=1 for MOV reg/MVN, else 0. ALU_op=00 for MOV reg, else IR op.
  - CMP: en_status=1, en_C=0 -> WAIT.
  - Others: en_C=1 -> WRITE_REG.
- WRITE_REG: w_addr=Rd, wb_sel=00, w_en=1 -> WAIT.
- w is low in every state except WAIT. Busy cycles after the s edge: MOV imm 2; MOV reg/MVN/CMP 4; ADD/AND 5.
- Simultaneous load and s in WAIT: IR captures in on that edge and DECODE uses the new IR.
- s held high: a new instruction starts each time WAIT is re-entered, one WAIT cycle between instructions.
- reset mid-instruction: next edge returns to WAIT and clears IR. No write enable is asserted in the reset cycle's successor.
- reset dominates load and s.
- sximm8/sximm5 are pure sign extension of the current IR, e.g. IR[7:0]=0x80 -> 0xFF80; IR[4:0]=0x10 -> 0xFFF0.

Test Plan:
- Reset, then idle 3 cycles -> w=1, all enables 0, sximm8=0x0000. Repeat with reset asserted mid-ADD at GET_B -> next cycle WAIT, w=1, no w_en.
- load 0xD107 (MOV R1,#7) + s -> DECODE, then WRITE_IMM with w_addr=1, wb_sel=10, w_en=1, sximm8=0x0007; w=1 two cycles after s.
- load 0xA248 (ADD R2,R2,R0,LSL#1) + s -> GET_A r_addr=2 en_A; GET_B r_addr=0 en_B; COMPUTE ALU_op=00 shift_op=01 en_C; WRITE_REG w_addr=2 w_en; 5 busy cycles.
- load 0xA901 (CMP R1,R1) + s -> COMPUTE en_status=1, en_C=0, never w_en; back to WAIT after 4 busy cycles.
- load 0xB8E3 (MVN R7,R3) + s -> no GET_A; COMPUTE sel_A=1, ALU_op=11; WRITE_REG w_addr=7; then 0xE000 (undefined) + s -> DECODE -> WAIT, no enables.
- During an ADD, pulse load with 0xFFFF -> IR unchanged. In WAIT, load=1 and s=1 in the same cycle with 0xD0FF -> R0 written with sximm8=0xFFFF.

Source files
------------

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Control stage for the 16-bit CPU datapath. It holds the instruction register
// (IR), decodes its fields and runs a Moore FSM. The FSM sequences the datapath
// enables so that one instruction executes per start pulse.
//
// Handshake: w=1 only in WAIT. On a rising edge in WAIT, load=1 captures `in`
// into IR and s=1 starts execution. Both strobes are ignored in every other
// state. When load and s are high on the same edge, the new IR is the one
// decoded.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   in[15:0]          instruction word, captured when load=1 in WAIT
//   load, s           IR load strobe / start strobe
//   w                 1 = idle in WAIT
//   r_addr, w_addr    register file read / write address
//   w_en, wb_sel      register file write enable / writeback source
//   en_A/B/C          datapath pipeline register loads
//   en_status         Z/N/V status load
//   sel_A, sel_B      ALU A forced to zero / ALU B taken from sximm5
//   ALU_op, shift_op  ALU operation / shifter operation (IR[4:3])
//   sximm8, sximm5    sign-extended IR[7:0] / IR[4:0]
// -----------------------------------------------------------------------------
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  r_addr,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [1:0]  wb_sel,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_COMPUTE   = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // IR field decode
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_mvn, is_alu3, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  // ADD, CMP and AND read both Rn and Rm.
  assign is_alu3    = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  assign shift_op = ir_q[4:3];
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

  // IR capture is only honoured while idle.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && load) ir_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_d   = state_q;
    w         = 1'b0;
    r_addr    = 3'b000;
    w_addr    = 3'b000;
    w_en      = 1'b0;
    wb_sel    = 2'b00;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = 2'b00;
    unique case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_WRITE_IMM;
        else if (is_alu3)              state_d = S_GET_A;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else                           state_d = S_WAIT;
      end
      S_WRITE_IMM: begin
        w_addr  = rn;
        wb_sel  = 2'b10;
        w_en    = 1'b1;
        state_d = S_WAIT;
      end
      S_GET_A: begin
        r_addr  = rn;
        en_A    = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        r_addr  = rm;
        en_B    = 1'b1;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        // MOV reg is an add with A forced to zero; MVN is not-B with A unused.
        sel_A  = is_mov_reg || is_mvn;
        ALU_op = is_mov_reg ? 2'b00 : op;
        if (is_cmp) begin
          en_status = 1'b1;
          state_d   = S_WAIT;
        end else begin
          en_C    = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        w_addr  = rd;
        wb_sel  = 2'b00;
        w_en    = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
